// File: rtl/accel_power_sequencer_if.sv
// rtl/accel_power_sequencer_if.sv - signal bundle between the top-level controller and the power sequencer
//
// Purpose: carries per-unit requests, bank needs and the resulting power controls.
// Signals:
//   unit_req          [NUM_UNITS]   controller -> sequencer, level clock request per unit
//   unit_busy         [NUM_UNITS]   controller -> sequencer, unit is in its compute phase
//   bank_need         [BRAM_BANKS]  controller -> sequencer, banks needed by the current state
//   unit_clk_en       [NUM_UNITS]   sequencer -> units, clock-gate enable
//   unit_dsp_en       [NUM_UNITS]   sequencer -> units, DSP operand enable
//   unit_ready        [NUM_UNITS]   sequencer -> controller, unit awake and banks settled
//   bank_power_en     [BRAM_BANKS]  sequencer -> BRAM, registered bank power enables
//   banks_stable                    sequencer -> controller, power enables match the target
//   active_bank_count [CNT_W]       sequencer -> controller, number of powered banks
// Modports: master = controller side, slave = sequencer side.

interface accel_power_sequencer_if #(
  parameter int NUM_UNITS  = 3,
  parameter int BRAM_BANKS = 20
);
  localparam int CNT_W = $clog2(BRAM_BANKS + 1);

  logic [NUM_UNITS-1:0]  unit_req;
  logic [NUM_UNITS-1:0]  unit_busy;
  logic [BRAM_BANKS-1:0] bank_need;
  logic [NUM_UNITS-1:0]  unit_clk_en;
  logic [NUM_UNITS-1:0]  unit_dsp_en;
  logic [NUM_UNITS-1:0]  unit_ready;
  logic [BRAM_BANKS-1:0] bank_power_en;
  logic                  banks_stable;
  logic [CNT_W-1:0]      active_bank_count;

  modport master (
    output unit_req, unit_busy, bank_need,
    input  unit_clk_en, unit_dsp_en, unit_ready, bank_power_en, banks_stable, active_bank_count
  );

  modport slave (
    input  unit_req, unit_busy, bank_need,
    output unit_clk_en, unit_dsp_en, unit_ready, bank_power_en, banks_stable, active_bank_count
  );
endinterface

// File: rtl/accel_power_sequencer.sv
// rtl/accel_power_sequencer.sv - per-unit clock wake/idle sequencing and staggered BRAM bank power control
//
// Purpose: one wake/idle FSM with idle hysteresis per compute unit (0=MLP, 1=CNN, 2=RNN, ...),
// plus a bank sequencer that powers banks up in limited groups and powers them down at once.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    accel_power_sequencer_if.slave:
//            in : unit_req, unit_busy, bank_need
//            out: unit_clk_en (registered), unit_dsp_en, unit_ready, bank_power_en (registered),
//                 banks_stable, active_bank_count

module accel_power_sequencer #(
  parameter int                    NUM_UNITS      = 3,
  parameter int                    BRAM_BANKS     = 20,
  parameter logic [BRAM_BANKS-1:0] ALWAYS_ON_MASK = 20'h0000F,
  parameter int                    WAKE_CYCLES    = 2,
  parameter int                    IDLE_TIMEOUT   = 16,
  parameter int                    BANKS_PER_STEP = 4,
  parameter int                    STEP_CYCLES    = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  accel_power_sequencer_if.slave bus
);

  localparam int CNT_W  = $clog2(BRAM_BANKS + 1);
  localparam int WAKE_W = (WAKE_CYCLES  > 1) ? $clog2(WAKE_CYCLES)  : 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int STEP_W = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;

  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_WAKE      = 2'd1,
    ST_ON        = 2'd2,
    ST_IDLE_WAIT = 2'd3
  } unit_state_t;

  // ---------------------------------------------------------------------------
  // Bank sequencer
  // ---------------------------------------------------------------------------
  logic [BRAM_BANKS-1:0] bank_en_q;
  logic [BRAM_BANKS-1:0] target;
  logic [BRAM_BANKS-1:0] pending;
  logic [BRAM_BANKS-1:0] grant;
  logic [STEP_W-1:0]     step_cnt;
  logic [CNT_W-1:0]      bank_count;
  logic                  banks_stable;
  int                    granted;

  assign target  = bus.bank_need | ALWAYS_ON_MASK;
  assign pending = target & ~bank_en_q;

  // Lowest-indexed pending banks, at most BANKS_PER_STEP of them.
  always_comb begin
    grant   = '0;
    granted = 0;
    for (int b = 0; b < BRAM_BANKS; b++) begin
      if (pending[b] && (granted < BANKS_PER_STEP)) begin
        grant[b] = 1'b1;
        granted  = granted + 1;
      end
    end
  end

  // Masking with target drops withdrawn banks on every edge, independent of the
  // step pacing; always-on banks stay set because target always contains them.
  // Because pending is taken from the current target, a bank withdrawn before
  // its group came up is simply never granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_en_q <= ALWAYS_ON_MASK;
      step_cnt  <= '0;
    end else if ((pending != '0) && (step_cnt == '0)) begin
      bank_en_q <= (bank_en_q & target) | grant;
      step_cnt  <= STEP_LOAD;
    end else begin
      bank_en_q <= bank_en_q & target;
      if (step_cnt != '0) begin
        step_cnt <= step_cnt - STEP_W'(1);
      end
    end
  end

  always_comb begin
    bank_count = '0;
    for (int b = 0; b < BRAM_BANKS; b++) begin
      bank_count = bank_count + CNT_W'(bank_en_q[b]);
    end
  end

  assign banks_stable          = (bank_en_q == target);
  assign bus.bank_power_en     = bank_en_q;
  assign bus.banks_stable      = banks_stable;
  assign bus.active_bank_count = bank_count;

  // ---------------------------------------------------------------------------
  // Per-unit wake/idle FSMs
  // ---------------------------------------------------------------------------
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    unit_state_t       state;
    logic [WAKE_W-1:0] wake_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              clk_en_q;
    logic              on_q;

    // clk_en_q and on_q are updated alongside the state so they always equal
    // (state != OFF) and (state == ON) without a decode after the flops.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state    <= ST_OFF;
        wake_cnt <= '0;
        idle_cnt <= '0;
        clk_en_q <= 1'b0;
        on_q     <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            if (bus.unit_req[u]) begin
              state    <= ST_WAKE;
              wake_cnt <= WAKE_LOAD;
              clk_en_q <= 1'b1;
            end
          end
          // Request level is ignored while waking; a drop is seen once ON.
          ST_WAKE: begin
            if (wake_cnt == '0) begin
              state <= ST_ON;
              on_q  <= 1'b1;
            end else begin
              wake_cnt <= wake_cnt - WAKE_W'(1);
            end
          end
          ST_ON: begin
            if (!bus.unit_req[u]) begin
              state    <= ST_IDLE_WAIT;
              idle_cnt <= IDLE_LOAD;
              on_q     <= 1'b0;
            end
          end
          // The clock keeps running here, so a returning request goes straight
          // back to ON without another wake delay.
          ST_IDLE_WAIT: begin
            if (bus.unit_req[u]) begin
              state <= ST_ON;
              on_q  <= 1'b1;
            end else if (idle_cnt == '0) begin
              state    <= ST_OFF;
              clk_en_q <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt - IDLE_W'(1);
            end
          end
          default: begin
            state    <= ST_OFF;
            clk_en_q <= 1'b0;
            on_q     <= 1'b0;
          end
        endcase
      end
    end

    assign bus.unit_clk_en[u] = clk_en_q;
    assign bus.unit_dsp_en[u] = on_q & bus.unit_busy[u];
    assign bus.unit_ready[u]  = on_q & banks_stable;
  end

endmodule

// File: tb/tb_accel_power_sequencer.sv
// tb/tb_accel_power_sequencer.sv - self-checking bench for accel_power_sequencer

module tb_accel_power_sequencer;
  localparam int             NU   = 3;
  localparam int             NB   = 20;
  localparam logic [NB-1:0]  AON  = 20'h0000F;
  localparam int             WAKE = 2;
  localparam int             IDLE = 16;
  localparam int             BPS  = 4;
  localparam int             STEP = 2;
  localparam int             CW   = $clog2(NB + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NU-1:0] req   = '0;
  logic [NU-1:0] busy  = '0;
  logic [NB-1:0] need  = '0;

  always #5 clk = ~clk;

  accel_power_sequencer_if #(.NUM_UNITS(NU), .BRAM_BANKS(NB)) bus ();

  assign bus.unit_req  = req;
  assign bus.unit_busy = busy;
  assign bus.bank_need = need;

  accel_power_sequencer #(
    .NUM_UNITS(NU), .BRAM_BANKS(NB), .ALWAYS_ON_MASK(AON), .WAKE_CYCLES(WAKE),
    .IDLE_TIMEOUT(IDLE), .BANKS_PER_STEP(BPS), .STEP_CYCLES(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a unit is described by how long its clock has been
  // running (m_age, -1 = clock off) and how many consecutive edges it has
  // seen without a request once awake (m_quiet). Banks are described by the
  // enabled set and the number of edges since the last power-up group.
  int            m_age   [NU];
  int            m_quiet [NU];
  logic [NB-1:0] m_en;
  int            m_since;

  logic [NU-1:0] exp_clk_en, exp_dsp, exp_ready;
  logic [NB-1:0] exp_en;
  logic          exp_stable;
  logic [CW-1:0] exp_cnt;

  task automatic tick();
    logic [NB-1:0] tgt, pend, nxt;
    int            k;
    @(posedge clk);
    if (!rst_n) begin
      for (int u = 0; u < NU; u++) begin
        m_age[u]   = -1;
        m_quiet[u] = 0;
      end
      m_en    = AON;
      m_since = STEP;
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (m_age[u] < 0) begin
          if (req[u]) m_age[u] = 0;
        end else if (m_age[u] < WAKE) begin
          m_age[u] = m_age[u] + 1;
        end else if (req[u]) begin
          m_quiet[u] = 0;
        end else begin
          m_quiet[u] = m_quiet[u] + 1;
          if (m_quiet[u] > IDLE) begin
            m_age[u]   = -1;
            m_quiet[u] = 0;
          end
        end
      end
      tgt  = need | AON;
      pend = tgt & ~m_en;
      nxt  = m_en & tgt;
      if (pend != '0 && m_since >= STEP) begin
        k = 0;
        for (int b = 0; b < NB; b++) begin
          if (pend[b] && k < BPS) begin
            nxt[b] = 1'b1;
            k++;
          end
        end
        m_since = 1;
      end else if (m_since < STEP) begin
        m_since++;
      end
      m_en = nxt;
    end
    #1;
  endtask

  task automatic model_outputs();
    logic [NB-1:0] tgt;
    logic          on;
    tgt = need | AON;
    for (int u = 0; u < NU; u++) begin
      on            = (m_age[u] >= WAKE) && (m_quiet[u] == 0);
      exp_clk_en[u] = (m_age[u] >= 0);
      exp_dsp[u]    = on && busy[u];
      exp_ready[u]  = on && (m_en == tgt);
    end
    exp_en     = m_en;
    exp_stable = (m_en == tgt);
    exp_cnt    = CW'($countones(m_en));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; busy = '0; need = '0;
    tick(); tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== AON) begin
      n_fail++; $display("FAIL reset_bank_en got %h want %h", bus.bank_power_en, AON);
    end
    rst_n = 1'b1;
    tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== 20'h0000F || bus.active_bank_count !== CW'(4) || bus.banks_stable !== 1'b1) begin
      n_fail++; $display("FAIL reset_banks got en=%h cnt=%0d st=%b want en=0000f cnt=4 st=1",
                         bus.bank_power_en, bus.active_bank_count, bus.banks_stable);
    end
    n_tests++;
    if (bus.unit_clk_en !== 3'b000 || bus.unit_dsp_en !== 3'b000 || bus.unit_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_units got clk=%b dsp=%b rdy=%b want all 0",
                         bus.unit_clk_en, bus.unit_dsp_en, bus.unit_ready);
    end
  endtask

  task automatic test_wake();
    logic [2:0] want_clk, want_rdy;
    req[0] = 1'b1; busy[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick(); #2;
      want_clk = 3'b001;
      want_rdy = (c >= 3) ? 3'b001 : 3'b000;
      n_tests++;
      if (bus.unit_clk_en !== want_clk || bus.unit_ready !== want_rdy || bus.unit_dsp_en !== want_rdy) begin
        n_fail++; $display("FAIL wake_c%0d got clk=%b rdy=%b dsp=%b want clk=%b rdy=%b dsp=%b",
                           c, bus.unit_clk_en, bus.unit_ready, bus.unit_dsp_en, want_clk, want_rdy, want_rdy);
      end
    end
    busy[0] = 1'b0; #1;
    n_tests++;
    if (bus.unit_dsp_en[0] !== 1'b0) begin
      n_fail++; $display("FAIL wake_busy_low got dsp=%b want 0", bus.unit_dsp_en[0]);
    end
  endtask

  task automatic test_stagger();
    logic [NB-1:0] tab [1:7];
    tab[1] = 20'h000FF; tab[2] = 20'h000FF; tab[3] = 20'h00FFF; tab[4] = 20'h00FFF;
    tab[5] = 20'h0FFFF; tab[6] = 20'h0FFFF; tab[7] = 20'hFFFFF;
    need = 20'hFFFF0;
    for (int c = 1; c <= 7; c++) begin
      tick(); #2;
      n_tests++;
      if (bus.bank_power_en !== tab[c] || bus.unit_ready[0] !== (c == 7) || bus.banks_stable !== (c == 7)) begin
        n_fail++; $display("FAIL stagger_c%0d got en=%h rdy0=%b st=%b want en=%h rdy0/st=%b",
                           c, bus.bank_power_en, bus.unit_ready[0], bus.banks_stable, tab[c], (c == 7));
      end
    end
    n_tests++;
    if (bus.active_bank_count !== CW'(20)) begin
      n_fail++; $display("FAIL stagger_count got %0d want 20", bus.active_bank_count);
    end
  endtask

  task automatic test_idle_hysteresis();
    int drops;
    req[1] = 1'b1; busy[1] = 1'b1;
    tick(); tick(); tick(); #2;
    n_tests++;
    if (bus.unit_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL hyst_on got rdy1=%b want 1", bus.unit_ready[1]);
    end
    req[1] = 1'b0;
    drops = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(); #2;
      if (bus.unit_clk_en[1] !== 1'b1 || bus.unit_dsp_en[1] !== 1'b0) drops++;
    end
    n_tests++;
    if (drops != 0) begin
      n_fail++; $display("FAIL hyst_idle_clk got %0d bad cycles want 0", drops);
    end
    req[1] = 1'b1;
    tick(); #2;
    n_tests++;
    if (bus.unit_clk_en[1] !== 1'b1 || bus.unit_dsp_en[1] !== 1'b1 || bus.unit_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL hyst_reon got clk=%b dsp=%b rdy=%b want 1 1 1",
                         bus.unit_clk_en[1], bus.unit_dsp_en[1], bus.unit_ready[1]);
    end
    req[1] = 1'b0;
    drops = 0;
    for (int c = 1; c <= 16; c++) begin
      tick(); #2;
      if (bus.unit_clk_en[1] !== 1'b1) drops++;
    end
    n_tests++;
    if (drops != 0) begin
      n_fail++; $display("FAIL hyst_hold got %0d gated cycles want 0", drops);
    end
    tick(); #2;
    n_tests++;
    if (bus.unit_clk_en[1] !== 1'b0) begin
      n_fail++; $display("FAIL hyst_gate got clk1=%b want 0", bus.unit_clk_en[1]);
    end
    busy[1] = 1'b0;
  endtask

  task automatic test_mid_stagger_drop();
    need = '0;
    tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== AON) begin
      n_fail++; $display("FAIL drop_all got %h want %h", bus.bank_power_en, AON);
    end
    tick(); tick();
    need = 20'hFFFF0;
    tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== 20'h000FF) begin
      n_fail++; $display("FAIL drop_first_group got %h want 000ff", bus.bank_power_en);
    end
    need = '0;
    for (int c = 2; c <= 3; c++) begin
      tick(); #2;
      n_tests++;
      if (bus.bank_power_en !== AON) begin
        n_fail++; $display("FAIL drop_pending_c%0d got %h want %h", c, bus.bank_power_en, AON);
      end
    end
    need = 20'h000F0;
    tick(); tick();
    need = 20'hFF000;
    tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== 20'h0F00F) begin
      n_fail++; $display("FAIL drop_same_edge got %h want 0f00f", bus.bank_power_en);
    end
    tick(); tick(); #2;
    n_tests++;
    if (bus.bank_power_en !== 20'hFF00F || bus.banks_stable !== 1'b1) begin
      n_fail++; $display("FAIL drop_regroup got en=%h st=%b want ff00f 1", bus.bank_power_en, bus.banks_stable);
    end
  endtask

  task automatic test_reset_mid();
    need = '0; req = 3'b011; busy = '0;
    tick(); tick();
    req[2] = 1'b1;
    tick();
    rst_n = 1'b0;
    tick(); #2;
    n_tests++;
    if (bus.unit_clk_en !== 3'b000 || bus.unit_ready !== 3'b000 || bus.bank_power_en !== AON ||
        bus.active_bank_count !== CW'(4)) begin
      n_fail++; $display("FAIL rstwake_state got clk=%b rdy=%b en=%h cnt=%0d want 000 000 0000f 4",
                         bus.unit_clk_en, bus.unit_ready, bus.bank_power_en, bus.active_bank_count);
    end
    rst_n = 1'b1;
    tick(); #2;
    n_tests++;
    if (bus.unit_clk_en !== 3'b111 || bus.unit_ready !== 3'b000) begin
      n_fail++; $display("FAIL rstwake_restart got clk=%b rdy=%b want 111 000", bus.unit_clk_en, bus.unit_ready);
    end
    tick(); tick(); #2;
    n_tests++;
    if (bus.unit_ready !== 3'b111) begin
      n_fail++; $display("FAIL rstwake_ready got %b want 111", bus.unit_ready);
    end
    req = '0;
    for (int c = 0; c < 5; c++) tick();
    #2;
    n_tests++;
    if (bus.unit_clk_en !== 3'b111) begin
      n_fail++; $display("FAIL rstidle_pre got clk=%b want 111", bus.unit_clk_en);
    end
    rst_n = 1'b0;
    tick(); #2;
    n_tests++;
    if (bus.unit_clk_en !== 3'b000) begin
      n_fail++; $display("FAIL rstidle_state got clk=%b want 000", bus.unit_clk_en);
    end
    rst_n = 1'b1;
    tick(); tick(); tick(); #2;
    n_tests++;
    if (bus.unit_clk_en !== 3'b000) begin
      n_fail++; $display("FAIL rstidle_off got clk=%b want 000", bus.unit_clk_en);
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; req = '0; busy = '0; need = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < NU; u++) begin
        if ($urandom_range(0, 11) == 0) req[u] = ~req[u];
      end
      busy = NU'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        need = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
      end
      rst_n = ($urandom_range(0, 149) != 0);
      #1;
      model_outputs();
      n_tests++;
      if ({bus.unit_clk_en, bus.unit_dsp_en, bus.unit_ready, bus.bank_power_en, bus.banks_stable,
           bus.active_bank_count} !== {exp_clk_en, exp_dsp, exp_ready, exp_en, exp_stable, exp_cnt}) begin
        n_fail++;
        $display("FAIL random_c%0d got clk=%b dsp=%b rdy=%b en=%h st=%b cnt=%0d want clk=%b dsp=%b rdy=%b en=%h st=%b cnt=%0d",
                 c, bus.unit_clk_en, bus.unit_dsp_en, bus.unit_ready, bus.bank_power_en, bus.banks_stable,
                 bus.active_bank_count, exp_clk_en, exp_dsp, exp_ready, exp_en, exp_stable, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_stagger();
    test_idle_hysteresis();
    test_mid_stagger_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_power_sequencer.md
# accel_power_sequencer

Parametrised power sequencer for the accelerator framework. It replaces per-state combinational gating with three mechanisms:
- a per-unit wake/idle state machine with hysteresis;
- staggered BRAM bank power-up, which limits inrush;
- immediate bank power-down.

It sits between the top-level controller and the compute units (MLP/CNN/RNN and future units). It drives clock enables, DSP operand isolation and BRAM bank power enables.

## Interface
Parameters:
- NUM_UNITS, 3: number of compute units (index 0=MLP, 1=CNN, 2=RNN).
- BRAM_BANKS, 20: number of BRAM banks.
- ALWAYS_ON_MASK, 20'h0000F: banks that are never powered down (input/output banks).
- WAKE_CYCLES, 2: cycles a unit's clock runs before the unit is declared ready; ≥1.
- IDLE_TIMEOUT, 16: cycles of no request before a unit's clock is gated; ≥1.
- BANKS_PER_STEP, 4: maximum banks enabled per power-up step; ≥1.
- STEP_CYCLES, 2: minimum cycles between power-up steps; ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- unit_req  in  NUM_UNITS  level request per unit; a unit needs its clock while this is high.
- unit_busy  in  NUM_UNITS  unit is in its compute phase; gates DSP operands.
- bank_need  in  BRAM_BANKS  banks required by the current controller state.
- unit_clk_en  out  NUM_UNITS  clock-gate enable per unit.
- unit_dsp_en  out  NUM_UNITS  DSP operand enable per unit.
- unit_ready  out  NUM_UNITS  unit awake and all requested banks powered.
- bank_power_en  out  BRAM_BANKS  registered bank power enables.
- banks_stable  out  1  high when bank_power_en == target.
- active_bank_count  out  $clog2(BRAM_BANKS+1)  popcount of bank_power_en.

## Operation
Unit FSM, one instance per unit i, states OFF, WAKE, ON, IDLE_WAIT:
- OFF: unit_clk_en[i]=0. If unit_req[i]=1, go to WAKE and load wake_cnt=WAKE_CYCLES-1.
- WAKE: unit_clk_en[i]=1.
  - If wake_cnt==0, go to ON; otherwise decrement wake_cnt.
  - unit_req is ignored while in WAKE; a dropped request is handled in ON.
- ON: unit_clk_en[i]=1. If unit_req[i]=0, go to IDLE_WAIT and load idle_cnt=IDLE_TIMEOUT-1.
- IDLE_WAIT: unit_clk_en[i]=1.
  - If unit_req[i]=1, go to ON; this has priority, and ON is re-entered with no wake delay.
  - Else if idle_cnt==0, go to OFF.
  - Otherwise decrement idle_cnt.
- unit_ready[i] = (state==ON) & banks_stable (combinational).
- unit_dsp_en[i] = (state==ON) & unit_busy[i] (combinational). It is 0 in WAKE and in IDLE_WAIT, even if busy is high.

Bank sequencer:
- target = bank_need | ALWAYS_ON_MASK.
- pending = target & ~bank_power_en.
- Power-down: any bank with bank_power_en=1 and target=0 clears at the next edge, regardless of the step counter.
- Power-up: step_cnt gates when power-up steps may occur.
  - If pending≠0 and step_cnt==0: set the lowest-indexed min(BANKS_PER_STEP, popcount(pending)) pending bits at the next edge, and load step_cnt=STEP_CYCLES-1.
  - Else if step_cnt≠0: decrement it.
  - Therefore a fresh request after a quiet period is served immediately.
- A bank whose request is withdrawn while it is still pending is never enabled.
- Power-down and power-up may occur on the same edge, on different bits.
- ALWAYS_ON_MASK bits are never cleared.
- banks_stable and active_bank_count are combinational from bank_power_en and target.

## Timing
Reset values (rst_n=0 at an edge):
- All unit FSMs go to OFF; wake_cnt, idle_cnt and step_cnt go to 0.
- bank_power_en=ALWAYS_ON_MASK.
- Hence unit_clk_en=0, unit_dsp_en=0, unit_ready=0, and active_bank_count=popcount(ALWAYS_ON_MASK).
- Reset asserted mid-operation (mid-wake, mid-idle or mid-staggering) discards all progress at that edge.

Unit latency:
- unit_req rises in cycle 0 → unit_clk_en=1 from cycle 1.
- The state is ON from cycle 1+WAKE_CYCLES; with defaults this is cycle 3.
- unit_req falls in cycle n (unit in ON) → unit_clk_en stays 1 through cycle n+IDLE_TIMEOUT and is 0 from cycle n+IDLE_TIMEOUT+1.

Bank latency:
- Groups of newly needed banks become visible at cycles 1, 1+STEP_CYCLES, 1+2·STEP_CYCLES, and so on, counted from the cycle bank_need changes.
- A dropped bank is 0 in the next cycle.
- All outputs are glitch-free with respect to clk.

## Test plan
- Reset, then release with bank_need=0 → bank_power_en=20'h0000F, active_bank_count=4, banks_stable=1, all unit outputs 0.
- unit_req[0]=1 at cycle 0 with bank_need=0 → unit_clk_en[0]=1 from cycle 1, unit_ready[0]=1 from cycle 3. Set unit_busy[0]=1 → unit_dsp_en[0]=1 only while ON.
- bank_need=20'hFFFF0 at cycle 0 → bank_power_en=0x000FF at cycle 1, 0x00FFF at 3, 0x0FFFF at 5, 0xFFFFF at 7. banks_stable=1 from cycle 7; unit_ready stays low until then.
- Drop unit_req[1] while ON, then re-raise it after 10 cycles → the unit returns to ON with no WAKE and unit_clk_en never drops. Drop it for 16 cycles → unit_clk_en=0 on the 17th cycle.
- Mid-staggering (after the first group), drop bank_need to 0 → all non-always-on banks clear next cycle and pending banks never assert. In the same cycle, re-request other banks → power-down and power-up happen on the same edge.
- Pulse rst_n=0 for one cycle during WAKE and during IDLE_WAIT → outputs reach reset values on that edge; the FSM restarts from OFF.
